// File: rtl/fetch_decode_unit_pkg.sv
// Shared encodings for the fetch/decode unit: instruction classes,
// execution-unit select codes, FSM state type and small arithmetic helpers.
package fetch_decode_unit_pkg;

   localparam logic [2:0] CLS_ARITH_I = 3'b000;
   localparam logic [2:0] CLS_ARITH   = 3'b001;
   localparam logic [2:0] CLS_HALT    = 3'b111;

   localparam logic [1:0] SEL_ARITH_I = 2'b00;
   localparam logic [1:0] SEL_ARITH   = 2'b01;

   typedef enum logic [2:0] {
      ST_FETCH_HI  = 3'd0,
      ST_FETCH_LO  = 3'd1,
      ST_DECODE    = 3'd2,
      ST_ISSUE     = 3'd3,
      ST_WAIT_BUSY = 3'd4,
      ST_WAIT_DONE = 3'd5,
      ST_HALT      = 3'd6
   } state_e;

   // Increment that sticks at all-ones instead of wrapping.
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage

// File: rtl/fetch_decode_unit_if.sv
// Bus bundle between the fetch/decode unit, the BIU and the execution unit.
// master = the fetch/decode unit, slave = the BIU/EU side.
interface fetch_decode_unit_if;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic [15:0] fetch_data;
   logic        fetch_ready;
   logic [31:0] ir;
   logic [1:0]  sel_eu;
   logic        cs_eu;
   logic        eu_ready;

   modport master (
      output fetch_req, fetch_addr, ir, sel_eu, cs_eu,
      input  fetch_data, fetch_ready, eu_ready
   );

   modport slave (
      input  fetch_req, fetch_addr, ir, sel_eu, cs_eu,
      output fetch_data, fetch_ready, eu_ready
   );
endinterface

// File: rtl/fetch_decode_unit_insn_decoder.sv
// Purely combinational class decoder: ir[31:29] -> {sel_eu, is_halt, is_illegal}.
module insn_decoder
   import fetch_decode_unit_pkg::*;
(
   input  logic [2:0] cls_i,
   output logic [1:0] sel_eu_o,
   output logic       is_halt_o,
   output logic       is_illegal_o
);

   // Map the instruction class to an execution select or a halt/illegal flag.
   always_comb begin
      sel_eu_o     = SEL_ARITH_I;
      is_halt_o    = 1'b0;
      is_illegal_o = 1'b0;
      case (cls_i)
         CLS_ARITH_I: sel_eu_o     = SEL_ARITH_I;
         CLS_ARITH:   sel_eu_o     = SEL_ARITH;
         CLS_HALT:    is_halt_o    = 1'b1;
         default:     is_illegal_o = 1'b1;
      endcase
   end

endmodule

// File: rtl/fetch_decode_unit.sv
// Two-word instruction fetch, class decode and issue to an execution unit.
// Every output is a register; the timeout counter bounds the wait for the
// execution unit to acknowledge a start by dropping eu_ready.
module fetch_decode_unit
   import fetch_decode_unit_pkg::*;
#(
   parameter logic [15:0] RESET_PC     = 16'h0000,
   parameter int          BUSY_TIMEOUT = 4
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                run_i,
   fetch_decode_unit_if.master bus,
   output logic [15:0]         pc_o,
   output logic                illegal_o,
   output logic                halted_o,
   output logic [15:0]         retired_o
);

   localparam int             TO_W    = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUSY_TIMEOUT - 1);

   state_e           state_q;
   logic [15:0]      pc_q;
   logic [31:0]      ir_q;
   logic [1:0]       sel_eu_q;
   logic             cs_eu_q;
   logic             fetch_req_q;
   logic [15:0]      fetch_addr_q;
   logic             illegal_q;
   logic             halted_q;
   logic [15:0]      retired_q;
   logic [TO_W-1:0]  to_cnt_q;

   logic [15:0]      pc_d;
   logic [15:0]      retired_d;
   logic [1:0]       dec_sel;
   logic             dec_halt;
   logic             dec_illegal;

   assign pc_d      = pc_q + 16'd2;
   assign retired_d = sat_inc16(retired_q);

   insn_decoder u_insn_decoder (
      .cls_i        (ir_q[31:29]),
      .sel_eu_o     (dec_sel),
      .is_halt_o    (dec_halt),
      .is_illegal_o (dec_illegal)
   );

   // Main sequencer: fetch two words, decode, issue, wait for the EU, retire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_FETCH_HI;
         pc_q         <= RESET_PC;
         ir_q         <= 32'h0000_0000;
         sel_eu_q     <= SEL_ARITH_I;
         cs_eu_q      <= 1'b0;
         fetch_req_q  <= 1'b0;
         fetch_addr_q <= RESET_PC;
         illegal_q    <= 1'b0;
         halted_q     <= 1'b0;
         retired_q    <= 16'h0000;
         to_cnt_q     <= {TO_W{1'b0}};
      end else begin
         cs_eu_q   <= 1'b0;
         illegal_q <= 1'b0;
         case (state_q)
            ST_FETCH_HI: begin
               // Once raised, the request is held until the BIU completes it,
               // regardless of run.
               if (!fetch_req_q) begin
                  if (run_i) begin
                     fetch_req_q  <= 1'b1;
                     fetch_addr_q <= pc_q;
                  end
               end else if (bus.fetch_ready) begin
                  ir_q[31:16] <= bus.fetch_data;
                  fetch_req_q <= 1'b0;
                  state_q     <= ST_FETCH_LO;
               end
            end
            ST_FETCH_LO: begin
               if (!fetch_req_q) begin
                  fetch_req_q  <= 1'b1;
                  fetch_addr_q <= pc_q + 16'd1;
               end else if (bus.fetch_ready) begin
                  ir_q[15:0]  <= bus.fetch_data;
                  fetch_req_q <= 1'b0;
                  state_q     <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (dec_halt) begin
                  halted_q <= 1'b1;
                  state_q  <= ST_HALT;
               end else if (dec_illegal) begin
                  illegal_q <= 1'b1;
                  pc_q      <= pc_d;
                  state_q   <= ST_FETCH_HI;
               end else begin
                  sel_eu_q <= dec_sel;
                  cs_eu_q  <= 1'b1;
                  state_q  <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               to_cnt_q <= {TO_W{1'b0}};
               state_q  <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (!bus.eu_ready || (to_cnt_q == TO_LAST)) begin
                  state_q <= ST_WAIT_DONE;
               end else begin
                  to_cnt_q <= to_cnt_q + TO_W'(1);
               end
            end
            ST_WAIT_DONE: begin
               if (bus.eu_ready) begin
                  pc_q      <= pc_d;
                  retired_q <= retired_d;
                  state_q   <= ST_FETCH_HI;
               end
            end
            ST_HALT: begin
               halted_q    <= 1'b1;
               fetch_req_q <= 1'b0;
            end
            default: begin
               state_q     <= ST_FETCH_HI;
               fetch_req_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.fetch_req  = fetch_req_q;
   assign bus.fetch_addr = fetch_addr_q;
   assign bus.ir         = ir_q;
   assign bus.sel_eu     = sel_eu_q;
   assign bus.cs_eu      = cs_eu_q;
   assign pc_o           = pc_q;
   assign illegal_o      = illegal_q;
   assign halted_o       = halted_q;
   assign retired_o      = retired_q;

endmodule

// File: tb/tb_fetch_decode_unit.sv
// Bench for fetch_decode_unit: behavioural BIU memory and EU responders plus an
// instruction-level reference model (next pc, class outcome, retire count).
module tb_fetch_decode_unit;
   import fetch_decode_unit_pkg::*;

   localparam logic [15:0] RPC = 16'hFFFE;
   localparam int          TMO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic [15:0] pc;
   logic        illegal;
   logic        halted;
   logic [15:0] retired;

   fetch_decode_unit_if bus();

   fetch_decode_unit #(.RESET_PC(RPC), .BUSY_TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst), .run_i(run), .bus(bus),
      .pc_o(pc), .illegal_o(illegal), .halted_o(halted), .retired_o(retired)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   // instruction memory seen by the BIU
   logic [15:0] mem [logic [15:0]];

   function automatic logic [15:0] rd(input logic [15:0] a);
      if (mem.exists(a)) return mem[a];
      return 16'h0000;
   endfunction

   // 0 = issued to EU, 1 = illegal, 2 = halt
   function automatic int exp_kind(input logic [15:0] hi);
      logic [2:0] c;
      c = hi[15:13];
      if (c == 3'b000 || c == 3'b001) return 0;
      if (c == 3'b111) return 2;
      return 1;
   endfunction

   // responder settings and observation records
   int          biu_lo = 0, biu_hi = 0, eu_lat = 0;
   int          cyc = 0, biu_wait = -1, eu_left = 0;
   logic [15:0] biu_addr = 16'h0000, last_req_addr = 16'h0000;
   int          req_count = 0, stab_err = 0, ready_cyc = 0;
   int          cs_cnt = 0, cs_cyc = 0, cs_lat = 0;
   logic [31:0] cs_ir = 32'h0;
   logic [1:0]  cs_sel = 2'b00;
   logic [15:0] cs_pc = 16'h0, cs_ret = 16'h0, ill_pc = 16'h0, prev_ret = 16'h0;
   int          ill_rise = 0, ill_cycles = 0, halt_req = 0, ret_cyc = 0;
   logic        prev_ill = 1'b0;

   // model state
   logic [15:0] m_pc  = RPC;
   logic [15:0] m_ret = 16'h0000;

   // BIU/EU responders and event recorder, evaluated 1 time unit after each edge
   initial begin
      bus.fetch_ready = 1'b0;
      bus.fetch_data  = 16'h0000;
      bus.eu_ready    = 1'b1;
      forever begin
         @(posedge clk); #1;
         cyc++;
         if (rst) begin
            biu_wait = -1; eu_left = 0;
            bus.fetch_ready = 1'b0; bus.eu_ready = 1'b1;
         end else begin
            if (bus.fetch_ready) begin
               bus.fetch_ready = 1'b0; biu_wait = -1;
            end else if (bus.fetch_req) begin
               if (biu_wait < 0) begin
                  biu_wait = $urandom_range(biu_hi, biu_lo);
                  biu_addr = bus.fetch_addr; last_req_addr = bus.fetch_addr;
                  req_count++;
               end else if (bus.fetch_addr !== biu_addr) stab_err++;
               if (biu_wait == 0) begin
                  bus.fetch_ready = 1'b1; bus.fetch_data = rd(biu_addr); ready_cyc = cyc;
               end else biu_wait--;
            end else if (biu_wait >= 0) stab_err++;
            if (eu_left > 0) begin bus.eu_ready = 1'b0; eu_left--; end
            else bus.eu_ready = 1'b1;
            if (bus.cs_eu) begin
               cs_cnt++; cs_cyc = cyc; cs_lat = cyc - ready_cyc;
               cs_ir = bus.ir; cs_sel = bus.sel_eu; cs_pc = pc; cs_ret = retired;
               eu_left = eu_lat;
            end
            if (halted && bus.fetch_req) halt_req++;
         end
         if (illegal && !prev_ill) begin ill_rise++; ill_pc = pc; end
         if (illegal) ill_cycles++;
         prev_ill = illegal;
         if (retired !== prev_ret) ret_cyc = cyc;
         prev_ret = retired;
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      m_pc = RPC; m_ret = 16'h0000;
   endtask

   // Wait for the next instruction outcome; for an issued one also wait for retire.
   task automatic wait_event(output int kind, output bit to);
      int c0, i0, n;
      c0 = cs_cnt; i0 = ill_rise; n = 0; kind = -1; to = 1'b0;
      while (kind < 0) begin
         @(posedge clk); #2;
         n++;
         if (cs_cnt != c0) kind = 0;
         else if (ill_rise != i0) kind = 1;
         else if (halted) kind = 2;
         else if (n > 200) begin kind = 3; to = 1'b1; end
      end
      if (kind == 0) begin
         n = 0;
         while (ret_cyc <= cs_cyc && n < 60) begin @(posedge clk); #2; n++; end
         if (n >= 60) to = 1'b1;
      end
   endtask

   task automatic wait_req(output bit to);
      int r0, n;
      r0 = req_count; n = 0; to = 1'b0;
      while (req_count == r0 && n < 100) begin @(posedge clk); #2; n++; end
      if (n >= 100) to = 1'b1;
   endtask

   task automatic test_reset();
      int r0;
      run = 1'b0;
      do_reset();
      n_checks++; if (pc !== RPC) $display("FAIL reset_pc: got %h want %h", pc, RPC); else n_pass++;
      n_checks++; if (retired !== 16'h0) $display("FAIL reset_retired: got %h want 0", retired); else n_pass++;
      n_checks++; if (halted !== 1'b0) $display("FAIL reset_halted: got %b want 0", halted); else n_pass++;
      n_checks++; if (illegal !== 1'b0) $display("FAIL reset_illegal: got %b want 0", illegal); else n_pass++;
      n_checks++; if (bus.cs_eu !== 1'b0) $display("FAIL reset_cs_eu: got %b want 0", bus.cs_eu); else n_pass++;
      n_checks++; if (bus.fetch_req !== 1'b0) $display("FAIL reset_req: got %b want 0", bus.fetch_req); else n_pass++;
      n_checks++; if (bus.fetch_addr !== RPC) $display("FAIL reset_addr: got %h want %h", bus.fetch_addr, RPC); else n_pass++;
      n_checks++; if (bus.ir !== 32'h0) $display("FAIL reset_ir: got %h want 0", bus.ir); else n_pass++;
      n_checks++; if (bus.sel_eu !== 2'b00) $display("FAIL reset_sel: got %b want 00", bus.sel_eu); else n_pass++;
      r0 = req_count;
      repeat (6) @(posedge clk); #2;
      n_checks++; if (bus.fetch_req !== 1'b0 || req_count != r0)
         $display("FAIL run_low_hold: req %b new requests %0d want 0/0", bus.fetch_req, req_count - r0); else n_pass++;
      n_checks++; if (pc !== RPC) $display("FAIL run_low_pc: got %h want %h", pc, RPC); else n_pass++;
   endtask

   // EU never drops eu_ready: completion by timeout, pc wraps FFFE -> 0000.
   task automatic test_timeout_wrap();
      int kind; bit to;
      biu_lo = 0; biu_hi = 0; eu_lat = 0; run = 1'b1;
      wait_event(kind, to);
      n_checks++; if (kind !== 0 || to) $display("FAIL tmo_kind: got %0d timeout %0d want 0", kind, to); else n_pass++;
      n_checks++; if (cs_ir !== {rd(RPC), rd(RPC + 16'd1)}) $display("FAIL tmo_ir: got %h want %h", cs_ir, {rd(RPC), rd(RPC + 16'd1)}); else n_pass++;
      n_checks++; if (ret_cyc - cs_cyc != TMO + 2) $display("FAIL tmo_delay: got %0d want %0d", ret_cyc - cs_cyc, TMO + 2); else n_pass++;
      n_checks++; if (pc !== 16'h0000) $display("FAIL tmo_pc_wrap: got %h want 0000", pc); else n_pass++;
      n_checks++; if (retired !== 16'd1) $display("FAIL tmo_retired: got %0d want 1", retired); else n_pass++;
      wait_req(to);
      n_checks++; if (to || last_req_addr !== 16'h0000) $display("FAIL tmo_next_addr: got %h timeout %0d want 0000", last_req_addr, to); else n_pass++;
      m_pc = 16'h0000; m_ret = 16'd1;
   endtask

   // arith_i with eu_ready low for 3 cycles.
   task automatic test_arith_i();
      int kind; bit to;
      eu_lat = 3;
      wait_event(kind, to);
      n_checks++; if (kind !== 0 || to) $display("FAIL ai_kind: got %0d timeout %0d want 0", kind, to); else n_pass++;
      n_checks++; if (cs_ir !== 32'h0000_0005) $display("FAIL ai_ir: got %h want 00000005", cs_ir); else n_pass++;
      n_checks++; if (cs_sel !== 2'b00) $display("FAIL ai_sel: got %b want 00", cs_sel); else n_pass++;
      n_checks++; if (cs_lat != 2) $display("FAIL ai_latency: got %0d want 2", cs_lat); else n_pass++;
      n_checks++; if (ret_cyc - cs_cyc != 5) $display("FAIL ai_delay: got %0d want 5", ret_cyc - cs_cyc); else n_pass++;
      n_checks++; if (pc !== 16'd2) $display("FAIL ai_pc: got %h want 0002", pc); else n_pass++;
      n_checks++; if (retired !== 16'd2) $display("FAIL ai_retired: got %0d want 2", retired); else n_pass++;
      m_pc = 16'd2; m_ret = 16'd2;
   endtask

   // arith with a slow BIU: request and address must hold while waiting.
   task automatic test_slow_biu();
      int kind; bit to; int s0;
      biu_lo = 5; biu_hi = 5; eu_lat = 1; s0 = stab_err;
      wait_event(kind, to);
      n_checks++; if (kind !== 0 || to) $display("FAIL slow_kind: got %0d timeout %0d want 0", kind, to); else n_pass++;
      n_checks++; if (stab_err != s0) $display("FAIL slow_stable: got %0d violations want 0", stab_err - s0); else n_pass++;
      n_checks++; if (cs_sel !== 2'b01) $display("FAIL slow_sel: got %b want 01", cs_sel); else n_pass++;
      n_checks++; if (cs_ir !== 32'h2000_ABCD) $display("FAIL slow_ir: got %h want 2000abcd", cs_ir); else n_pass++;
      m_pc = 16'd4; m_ret = 16'd3;
      biu_lo = 0; biu_hi = 3;
   endtask

   // Undecodable class: illegal pulse, no issue, pc += 2, retired unchanged.
   task automatic test_illegal();
      int kind; bit to; int c0, k0;
      c0 = cs_cnt; k0 = ill_cycles;
      wait_event(kind, to);
      repeat (2) @(posedge clk); #2;
      n_checks++; if (kind !== 1 || to) $display("FAIL ill_kind: got %0d timeout %0d want 1", kind, to); else n_pass++;
      n_checks++; if (ill_cycles - k0 != 1) $display("FAIL ill_width: got %0d cycles want 1", ill_cycles - k0); else n_pass++;
      n_checks++; if (cs_cnt != c0) $display("FAIL ill_no_cs: got %0d pulses want 0", cs_cnt - c0); else n_pass++;
      n_checks++; if (ill_pc !== 16'd6) $display("FAIL ill_pc: got %h want 0006", ill_pc); else n_pass++;
      n_checks++; if (retired !== m_ret) $display("FAIL ill_retired: got %0d want %0d", retired, m_ret); else n_pass++;
      m_pc = 16'd6;
   endtask

   // Random instruction stream checked against the instruction-level model.
   task automatic test_random();
      int kind; bit to; int ek; int lat; logic [15:0] hi; logic [31:0] ew;
      for (int i = 0; i < 24; i++) begin
         hi = rd(m_pc); ek = exp_kind(hi); ew = {hi, rd(m_pc + 16'd1)};
         if (ek == 2) break;
         lat = $urandom_range(5, 0); eu_lat = lat;
         wait_event(kind, to);
         n_checks++; if (kind !== ek || to) $display("FAIL rnd%0d_kind: got %0d timeout %0d want %0d", i, kind, to, ek); else n_pass++;
         if (ek == 0) begin
            n_checks++; if (cs_ir !== ew) $display("FAIL rnd%0d_ir: got %h want %h", i, cs_ir, ew); else n_pass++;
            n_checks++; if (cs_sel !== ((hi[15:13] == 3'b001) ? 2'b01 : 2'b00)) $display("FAIL rnd%0d_sel: got %b class %b", i, cs_sel, hi[15:13]); else n_pass++;
            n_checks++; if (cs_pc !== m_pc || cs_ret !== m_ret) $display("FAIL rnd%0d_issue_state: pc %h ret %0d want %h %0d", i, cs_pc, cs_ret, m_pc, m_ret); else n_pass++;
            n_checks++; if (cs_lat != 2) $display("FAIL rnd%0d_latency: got %0d want 2", i, cs_lat); else n_pass++;
            n_checks++; if (ret_cyc - cs_cyc != ((lat == 0) ? TMO + 2 : lat + 2)) $display("FAIL rnd%0d_delay: got %0d lat %0d", i, ret_cyc - cs_cyc, lat); else n_pass++;
            m_pc = m_pc + 16'd2;
            if (m_ret != 16'hFFFF) m_ret = m_ret + 16'd1;
            n_checks++; if (pc !== m_pc || retired !== m_ret) $display("FAIL rnd%0d_retire: pc %h ret %0d want %h %0d", i, pc, retired, m_pc, m_ret); else n_pass++;
         end else begin
            m_pc = m_pc + 16'd2;
            n_checks++; if (ill_pc !== m_pc || retired !== m_ret) $display("FAIL rnd%0d_illegal: pc %h ret %0d want %h %0d", i, ill_pc, retired, m_pc, m_ret); else n_pass++;
         end
      end
      n_checks++; if (stab_err != 0) $display("FAIL rnd_bus_stable: got %0d violations want 0", stab_err); else n_pass++;
   endtask

   // HALT: sticky, no fetches or issues, only reset restarts at RESET_PC.
   task automatic test_halt();
      int kind; bit to; int h0, c0;
      n_checks++; if (exp_kind(rd(m_pc)) != 2) $display("FAIL halt_setup: class at %h not halt", m_pc); else n_pass++;
      wait_event(kind, to);
      n_checks++; if (kind !== 2 || to) $display("FAIL halt_kind: got %0d timeout %0d want 2", kind, to); else n_pass++;
      h0 = halt_req; c0 = cs_cnt;
      repeat (20) @(posedge clk); #2;
      n_checks++; if (halted !== 1'b1) $display("FAIL halt_level: got %b want 1", halted); else n_pass++;
      n_checks++; if (halt_req != h0 || bus.fetch_req !== 1'b0) $display("FAIL halt_no_fetch: got %0d req cycles want 0", halt_req - h0); else n_pass++;
      n_checks++; if (cs_cnt != c0) $display("FAIL halt_no_cs: got %0d pulses want 0", cs_cnt - c0); else n_pass++;
      do_reset();
      n_checks++; if (halted !== 1'b0) $display("FAIL halt_cleared: got %b want 0", halted); else n_pass++;
      wait_req(to);
      n_checks++; if (to || last_req_addr !== RPC) $display("FAIL halt_restart_addr: got %h timeout %0d want %h", last_req_addr, to, RPC); else n_pass++;
   endtask

   // Reset asserted while waiting for EU completion.
   task automatic test_reset_in_wait_done();
      int kind; bit to; int c0, n;
      do_reset();
      eu_lat = 0;
      wait_event(kind, to);
      n_checks++; if (retired !== 16'd1 || to) $display("FAIL rwd_pre_retired: got %0d want 1", retired); else n_pass++;
      eu_lat = 10; c0 = cs_cnt; n = 0;
      while (cs_cnt == c0 && n < 100) begin @(posedge clk); #2; n++; end
      n_checks++; if (cs_cnt == c0) $display("FAIL rwd_issue: got no cs_eu want 1"); else n_pass++;
      repeat (4) @(posedge clk);
      #3 rst = 1'b1;
      #1;
      n_checks++; if (retired !== 16'h0) $display("FAIL rwd_retired: got %0d want 0", retired); else n_pass++;
      n_checks++; if (pc !== RPC) $display("FAIL rwd_pc: got %h want %h", pc, RPC); else n_pass++;
      n_checks++; if (bus.ir !== 32'h0 || bus.sel_eu !== 2'b00) $display("FAIL rwd_ir_sel: got %h %b want 0 00", bus.ir, bus.sel_eu); else n_pass++;
      n_checks++; if (bus.cs_eu !== 1'b0 || bus.fetch_req !== 1'b0) $display("FAIL rwd_strobes: got cs %b req %b want 0 0", bus.cs_eu, bus.fetch_req); else n_pass++;
      n_checks++; if (bus.fetch_addr !== RPC) $display("FAIL rwd_addr: got %h want %h", bus.fetch_addr, RPC); else n_pass++;
      n_checks++; if (illegal !== 1'b0 || halted !== 1'b0) $display("FAIL rwd_flags: got %b %b want 0 0", illegal, halted); else n_pass++;
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;
      wait_req(to);
      n_checks++; if (to || last_req_addr !== RPC) $display("FAIL rwd_restart_addr: got %h timeout %0d want %h", last_req_addr, to, RPC); else n_pass++;
   endtask

   initial begin
      logic [15:0] a;
      mem[16'hFFFE] = 16'h0000; mem[16'hFFFF] = 16'h1234;
      mem[16'h0000] = 16'h0000; mem[16'h0001] = 16'h0005;
      mem[16'h0002] = 16'h2000; mem[16'h0003] = 16'hABCD;
      mem[16'h0004] = 16'h6000; mem[16'h0005] = 16'h0F0F;
      a = 16'h0006;
      for (int i = 0; i < 20; i++) begin
         mem[a] = {3'($urandom_range(6, 0)), 13'($urandom)};
         mem[a + 16'd1] = 16'($urandom);
         a = a + 16'd2;
      end
      mem[a] = 16'hE000; mem[a + 16'd1] = 16'h0000;

      test_reset();
      test_timeout_wrap();
      test_arith_i();
      test_slow_biu();
      test_illegal();
      test_random();
      test_halt();
      test_reset_in_wait_done();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
